// File: rtl/axi4_wb_dropper_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_wb_dropper_if
// Purpose  : Bundles the announcement, slave/master W and B channels of the
//            write-path dropper. Length ports exist only with
//            AXI4_WB_LEN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface axi4_wb_dropper_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4
);
  logic                        trans_valid;
  logic                        trans_ready;
  logic [AXI_ID_WIDTH-1:0]     trans_id;
  logic                        trans_drop;
  logic                        trans_prefetch;
`ifdef AXI4_WB_LEN_CHECK_EN
  logic [7:0]                  trans_len;
  logic                        len_err;
`endif

  logic [AXI_DATA_WIDTH-1:0]   s_axi4_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] s_axi4_wstrb;
  logic                        s_axi4_wlast;
  logic [AXI_USER_WIDTH-1:0]   s_axi4_wuser;
  logic                        s_axi4_wvalid;
  logic                        s_axi4_wready;

  logic [AXI_DATA_WIDTH-1:0]   m_axi4_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] m_axi4_wstrb;
  logic                        m_axi4_wlast;
  logic [AXI_USER_WIDTH-1:0]   m_axi4_wuser;
  logic                        m_axi4_wvalid;
  logic                        m_axi4_wready;

  logic [AXI_ID_WIDTH-1:0]     m_axi4_bid;
  logic [1:0]                  m_axi4_bresp;
  logic [AXI_USER_WIDTH-1:0]   m_axi4_buser;
  logic                        m_axi4_bvalid;
  logic                        m_axi4_bready;

  logic [AXI_ID_WIDTH-1:0]     s_axi4_bid;
  logic [1:0]                  s_axi4_bresp;
  logic [AXI_USER_WIDTH-1:0]   s_axi4_buser;
  logic                        s_axi4_bvalid;
  logic                        s_axi4_bready;

  // Block-side view.
  modport slave (
    input  trans_valid, trans_id, trans_drop, trans_prefetch,
    output trans_ready,
    input  s_axi4_wdata, s_axi4_wstrb, s_axi4_wlast, s_axi4_wuser, s_axi4_wvalid,
    output s_axi4_wready,
    output m_axi4_wdata, m_axi4_wstrb, m_axi4_wlast, m_axi4_wuser, m_axi4_wvalid,
    input  m_axi4_wready,
    input  m_axi4_bid, m_axi4_bresp, m_axi4_buser, m_axi4_bvalid,
    output m_axi4_bready,
    output s_axi4_bid, s_axi4_bresp, s_axi4_buser, s_axi4_bvalid,
    input  s_axi4_bready
`ifdef AXI4_WB_LEN_CHECK_EN
    , input trans_len, output len_err
`endif
  );

  // Environment-side view.
  modport master (
    output trans_valid, trans_id, trans_drop, trans_prefetch,
    input  trans_ready,
    output s_axi4_wdata, s_axi4_wstrb, s_axi4_wlast, s_axi4_wuser, s_axi4_wvalid,
    input  s_axi4_wready,
    input  m_axi4_wdata, m_axi4_wstrb, m_axi4_wlast, m_axi4_wuser, m_axi4_wvalid,
    output m_axi4_wready,
    output m_axi4_bid, m_axi4_bresp, m_axi4_buser, m_axi4_bvalid,
    input  m_axi4_bready,
    input  s_axi4_bid, s_axi4_bresp, s_axi4_buser, s_axi4_bvalid,
    output s_axi4_bready
`ifdef AXI4_WB_LEN_CHECK_EN
    , output trans_len, input len_err
`endif
  );
endinterface
`default_nettype wire

// File: rtl/axi4_wb_dropper.sv
`default_nettype none
// ============================================================================
// Module   : axi4_wb_dropper
// Purpose  : Forwards W beats of kept bursts, sinks dropped bursts and merges
//            an injected B per dropped burst into the master B stream.
//            Optional beat-count termination: AXI4_WB_LEN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_wb_dropper #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4,
  parameter int ORDER_DEPTH    = 4,
  parameter int DROP_DEPTH     = 4
) (
  input logic              axi4_aclk,
  input logic              axi4_arstn,
  axi4_wb_dropper_if.slave bus
);
  localparam int OAW = $clog2(ORDER_DEPTH);
  localparam int DAW = $clog2(DROP_DEPTH);

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_FWD  = 2'd1,
    B_INJ  = 2'd2
  } b_state_e;

  logic                      r_rst_done;
  logic [OAW:0]              r_ord_wptr;
  logic [OAW:0]              r_ord_rptr;
  logic                      r_ord_drop [ORDER_DEPTH];
  logic                      r_ord_pf   [ORDER_DEPTH];
  logic [AXI_ID_WIDTH-1:0]   r_ord_id   [ORDER_DEPTH];
  logic [DAW:0]              r_drp_wptr;
  logic [DAW:0]              r_drp_rptr;
  logic                      r_drp_pf   [DROP_DEPTH];
  logic [AXI_ID_WIDTH-1:0]   r_drp_id   [DROP_DEPTH];
  b_state_e                  r_b_state;
  logic [AXI_ID_WIDTH-1:0]   r_inj_id;
  logic [1:0]                r_inj_resp;

  logic                      w_ord_empty;
  logic                      w_ord_full;
  logic                      w_ord_push;
  logic                      w_ord_pop;
  logic                      w_drp_empty;
  logic                      w_drp_full;
  logic                      w_drp_push;
  logic                      w_drp_pop;
  logic                      w_keep;
  logic                      w_sink;
  logic                      w_term;
  logic                      w_sink_ready;
  logic                      w_sink_beat;
  logic [AXI_DATA_WIDTH-1:0] w_wdata;
  logic [AXI_USER_WIDTH-1:0] w_inj_user;
  logic [OAW-1:0]            w_ord_head;
  logic [DAW-1:0]            w_drp_head;

  assign w_ord_head  = r_ord_rptr[OAW-1:0];
  assign w_drp_head  = r_drp_rptr[DAW-1:0];
  assign w_ord_empty = (r_ord_wptr == r_ord_rptr);
  assign w_ord_full  = (r_ord_wptr[OAW] != r_ord_rptr[OAW]) &&
                       (r_ord_wptr[OAW-1:0] == r_ord_rptr[OAW-1:0]);
  assign w_drp_empty = (r_drp_wptr == r_drp_rptr);
  assign w_drp_full  = (r_drp_wptr[DAW] != r_drp_rptr[DAW]) &&
                       (r_drp_wptr[DAW-1:0] == r_drp_rptr[DAW-1:0]);

  // r_rst_done holds trans_ready low while reset is asserted.
  assign bus.trans_ready = r_rst_done & ~w_ord_full;
  assign w_ord_push      = bus.trans_valid & bus.trans_ready;

  assign w_keep = ~w_ord_empty & ~r_ord_drop[w_ord_head];
  assign w_sink = ~w_ord_empty &  r_ord_drop[w_ord_head];

`ifdef AXI4_WB_LEN_CHECK_EN
  logic [7:0] r_ord_len [ORDER_DEPTH];
  logic [7:0] r_beat_cnt;
  logic       r_len_err;

  assign w_term      = (r_beat_cnt == r_ord_len[w_ord_head]);
  assign bus.len_err = r_len_err;

  always_ff @(posedge axi4_aclk) begin
    if (w_ord_push) begin
      r_ord_len[r_ord_wptr[OAW-1:0]] <= bus.trans_len;
    end
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      r_beat_cnt <= 8'd0;
      r_len_err  <= 1'b0;
    end else if (w_sink_beat) begin
      r_beat_cnt <= w_term ? 8'd0 : r_beat_cnt + 8'd1;
      if (bus.s_axi4_wlast != w_term) begin
        r_len_err <= 1'b1;
      end
    end
  end
`else
  assign w_term = bus.s_axi4_wlast;
`endif

  // Only the terminating beat of a dropped burst needs room for its B.
  assign w_sink_ready = ~w_term | ~w_drp_full;
  assign w_sink_beat  = w_sink & bus.s_axi4_wvalid & w_sink_ready;
  assign w_drp_push   = w_sink_beat & w_term;
  assign w_ord_pop    = (w_keep & bus.s_axi4_wvalid & bus.m_axi4_wready & bus.s_axi4_wlast) |
                        w_drp_push;

  assign w_wdata           = bus.s_axi4_wdata;
  assign bus.m_axi4_wdata  = w_wdata;
  assign bus.m_axi4_wstrb  = bus.s_axi4_wstrb;
  assign bus.m_axi4_wlast  = bus.s_axi4_wlast;
  assign bus.m_axi4_wuser  = bus.s_axi4_wuser;
  assign bus.m_axi4_wvalid = w_keep & bus.s_axi4_wvalid;
  assign bus.s_axi4_wready = w_keep ? bus.m_axi4_wready : (w_sink & w_sink_ready);

  always_ff @(posedge axi4_aclk) begin
    if (w_ord_push) begin
      r_ord_drop[r_ord_wptr[OAW-1:0]] <= bus.trans_drop;
      r_ord_pf[r_ord_wptr[OAW-1:0]]   <= bus.trans_prefetch;
      r_ord_id[r_ord_wptr[OAW-1:0]]   <= bus.trans_id;
    end
    if (w_drp_push) begin
      r_drp_pf[r_drp_wptr[DAW-1:0]] <= r_ord_pf[w_ord_head];
      r_drp_id[r_drp_wptr[DAW-1:0]] <= r_ord_id[w_ord_head];
    end
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      r_rst_done <= 1'b0;
      r_ord_wptr <= '0;
      r_ord_rptr <= '0;
      r_drp_wptr <= '0;
      r_drp_rptr <= '0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_ord_push) r_ord_wptr <= r_ord_wptr + (OAW+1)'(1);
      if (w_ord_pop)  r_ord_rptr <= r_ord_rptr + (OAW+1)'(1);
      if (w_drp_push) r_drp_wptr <= r_drp_wptr + (DAW+1)'(1);
      if (w_drp_pop)  r_drp_rptr <= r_drp_rptr + (DAW+1)'(1);
    end
  end

  // B merge: injection wins in IDLE; the chosen source is held until handshake.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      r_b_state  <= B_IDLE;
      r_inj_id   <= '0;
      r_inj_resp <= 2'b00;
    end else begin
      case (r_b_state)
        B_IDLE: begin
          if (!w_drp_empty) begin
            r_b_state  <= B_INJ;
            r_inj_id   <= r_drp_id[w_drp_head];
            r_inj_resp <= r_drp_pf[w_drp_head] ? 2'b00 : 2'b10;
          end else if (bus.m_axi4_bvalid) begin
            r_b_state <= B_FWD;
          end
        end
        B_FWD: if (bus.m_axi4_bvalid && bus.s_axi4_bready) r_b_state <= B_IDLE;
        B_INJ: if (bus.s_axi4_bready) r_b_state <= B_IDLE;
        default: r_b_state <= B_IDLE;
      endcase
    end
  end

  assign w_inj_user        = '0;
  assign w_drp_pop         = (r_b_state == B_INJ) & bus.s_axi4_bready;
  assign bus.m_axi4_bready = (r_b_state == B_FWD) & bus.s_axi4_bready;
  assign bus.s_axi4_bvalid = (r_b_state == B_INJ) | ((r_b_state == B_FWD) & bus.m_axi4_bvalid);
  assign bus.s_axi4_bid    = (r_b_state == B_INJ) ? r_inj_id   : bus.m_axi4_bid;
  assign bus.s_axi4_bresp  = (r_b_state == B_INJ) ? r_inj_resp : bus.m_axi4_bresp;
  assign bus.s_axi4_buser  = (r_b_state == B_INJ) ? w_inj_user : bus.m_axi4_buser;
endmodule
`default_nettype wire
